rob_commit_unit: RTL and testbench

In-order retirement stage for the reorder buffer; it sits directly downstream of the ROB head/tail pointer block. It stores per-entry destination, result and completion state, and captures writebacks by ROB tag. It retires the entry at the current head to the architectural register file. Each retirement produces a one-cycle `updateHead_o` pulse that the pointer block uses to advance the head.

---
 rtl/rob_commit_unit.sv | 126 ++++++++++++
 tb/tb_rob_commit_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// Reorder-buffer retirement stage: per-entry completion tracking and
// in-order commit of the head entry to the architectural register file.
module rob_commit_unit #(
  parameter int ROBsize      = 8,
  parameter int addrSize     = $clog2(ROBsize),
  parameter int dataWidth    = 32,
  parameter int regAddrWidth = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    alloc_i,
  input  logic [addrSize-1:0]     allocTag_i,
  input  logic [regAddrWidth-1:0] allocDest_i,
  input  logic                    wbValid_i,
  input  logic [addrSize-1:0]     wbTag_i,
  input  logic [dataWidth-1:0]    wbData_i,
  input  logic                    flush_i,
  input  logic [addrSize-1:0]     head_i,
  output logic                    commitValid_o,
  output logic [regAddrWidth-1:0] commitDest_o,
  output logic [dataWidth-1:0]    commitData_o,
  output logic                    updateHead_o,
  output logic                    robEmpty_o
);

  typedef enum logic {CHECK, ADVANCE} state_t;

  state_t state_q, state_d;

  logic [ROBsize-1:0]      valid_q;
  logic [ROBsize-1:0]      done_q;
  logic [regAddrWidth-1:0] dest_q [ROBsize];
  logic [dataWidth-1:0]    data_q [ROBsize];

  logic                    commit_valid_q;
  logic                    update_head_q;
  logic [regAddrWidth-1:0] commit_dest_q;
  logic [dataWidth-1:0]    commit_data_q;

  logic head_ready;
  logic take;

  assign head_ready = valid_q[head_i] & done_q[head_i];

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    if (flush_i) begin
      state_d = CHECK;
    end else begin
      unique case (state_q)
        CHECK: begin
          if (head_ready) begin
            take    = 1'b1;
            state_d = ADVANCE;
          end
        end
        ADVANCE: state_d = CHECK;
        default: state_d = CHECK;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      commit_valid_q <= 1'b0;
      update_head_q  <= 1'b0;
      commit_dest_q  <= '0;
      commit_data_q  <= '0;
    end else if (flush_i) begin
      commit_valid_q <= 1'b0;
      update_head_q  <= 1'b0;
    end else begin
      commit_valid_q <= take;
      update_head_q  <= take;
      if (take) begin
        commit_dest_q <= dest_q[head_i];
        commit_data_q <= data_q[head_i];
      end
    end
  end

  // Later assignments win: commit clear, then writeback, then allocation.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < ROBsize; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (take) begin
        valid_q[head_i] <= 1'b0;
      end
      if (wbValid_i && valid_q[wbTag_i]) begin
        done_q[wbTag_i] <= 1'b1;
        data_q[wbTag_i] <= wbData_i;
      end
      if (alloc_i) begin
        valid_q[allocTag_i] <= 1'b1;
        done_q[allocTag_i]  <= 1'b0;
        dest_q[allocTag_i]  <= allocDest_i;
      end
    end
  end

  // A flush landing in the ADVANCE cycle cancels the pending pulse.
  assign commitValid_o = commit_valid_q & ~flush_i;
  assign updateHead_o  = update_head_q & ~flush_i;
  assign commitDest_o  = commit_dest_q;
  assign commitData_o  = commit_data_q;
  assign robEmpty_o    = ~|valid_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit; the bench plays the pointer block
// and advances head_i one cycle after each updateHead_o pulse.
module tb_rob_commit_unit;

  localparam int ROBsize      = 8;
  localparam int addrSize     = 3;
  localparam int dataWidth    = 32;
  localparam int regAddrWidth = 5;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    alloc;
  logic [addrSize-1:0]     alloc_tag;
  logic [regAddrWidth-1:0] alloc_dest;
  logic                    wb_valid;
  logic [addrSize-1:0]     wb_tag;
  logic [dataWidth-1:0]    wb_data;
  logic                    flush;
  logic [addrSize-1:0]     head;
  logic                    commit_valid;
  logic [regAddrWidth-1:0] commit_dest;
  logic [dataWidth-1:0]    commit_data;
  logic                    update_head;
  logic                    rob_empty;

  int checks   = 0;
  int failures = 0;

  rob_commit_unit #(
    .ROBsize(ROBsize),
    .addrSize(addrSize),
    .dataWidth(dataWidth),
    .regAddrWidth(regAddrWidth)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .alloc_i(alloc),
    .allocTag_i(alloc_tag),
    .allocDest_i(alloc_dest),
    .wbValid_i(wb_valid),
    .wbTag_i(wb_tag),
    .wbData_i(wb_data),
    .flush_i(flush),
    .head_i(head),
    .commitValid_o(commit_valid),
    .commitDest_o(commit_dest),
    .commitData_o(commit_data),
    .updateHead_o(update_head),
    .robEmpty_o(rob_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    alloc    = 1'b0;
    wb_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_alloc(input logic [addrSize-1:0] t,
                          input logic [regAddrWidth-1:0] d);
    alloc      = 1'b1;
    alloc_tag  = t;
    alloc_dest = d;
  endtask

  task automatic do_wb(input logic [addrSize-1:0] t,
                       input logic [dataWidth-1:0] d);
    wb_valid = 1'b1;
    wb_tag   = t;
    wb_data  = d;
  endtask

  task automatic pulse(input string tag, input logic exp);
    #1;
    chk({tag, "_cv"}, commit_valid, exp);
    chk({tag, "_uh"}, update_head, exp);
  endtask

  task automatic commit(input string tag, input logic [4:0] d,
                        input logic [31:0] v);
    pulse(tag, 1'b1);
    chk({tag, "_dest"}, commit_dest, d);
    chk({tag, "_data"}, commit_data, v);
  endtask

  logic [31:0] wb_vals [3];

  initial begin
    reset      = 1'b1;
    alloc      = 1'b0;
    alloc_tag  = '0;
    alloc_dest = '0;
    wb_valid   = 1'b0;
    wb_tag     = '0;
    wb_data    = '0;
    flush      = 1'b0;
    head       = '0;
    wb_vals[0] = 32'h0000_00AA;
    wb_vals[1] = 32'h0000_0011;
    wb_vals[2] = 32'h0000_0022;

    #12;
    reset = 1'b0;

    // reset state held with no stimulus
    for (int i = 0; i < 10; i++) begin
      nxt();
      pulse("rst", 1'b0);
      chk("rst_empty", rob_empty, 1'b1);
      chk("rst_dest", commit_dest, 5'd0);
      chk("rst_data", commit_data, 32'd0);
    end

    // single allocate / writeback / retire
    nxt(); do_alloc(3'd0, 5'd3);
    nxt(); do_wb(3'd0, 32'hDEAD_BEEF);
    chk("one_notempty", rob_empty, 1'b0);
    nxt(); pulse("one_wait", 1'b0);
    nxt(); commit("one", 5'd3, 32'hDEAD_BEEF);
    chk("one_empty", rob_empty, 1'b1);
    nxt(); head = 3'd1; pulse("one_after", 1'b0);
    chk("one_empty2", rob_empty, 1'b1);

    // out-of-order writeback, in-order retirement
    head = 3'd0;
    nxt(); do_alloc(3'd0, 5'd10);
    nxt(); do_alloc(3'd1, 5'd11);
    nxt(); do_alloc(3'd2, 5'd12);
    nxt(); do_wb(3'd2, wb_vals[2]);
    nxt(); do_wb(3'd1, wb_vals[1]); pulse("ooo_w2", 1'b0);
    nxt(); do_wb(3'd0, wb_vals[0]); pulse("ooo_w1", 1'b0);
    nxt(); pulse("ooo_w0", 1'b0);
    for (int i = 0; i < 3; i++) begin
      nxt(); commit("ooo", 5'(10 + i), wb_vals[i]);
      nxt(); head = 3'(i + 1); pulse("ooo_gap", 1'b0);
    end
    chk("ooo_empty", rob_empty, 1'b1);

    // head wraps from 7 to 0
    head = 3'd7;
    nxt(); do_alloc(3'd7, 5'd7);
    nxt(); do_wb(3'd7, 32'h7777_7777);
    nxt(); pulse("wrap7_wait", 1'b0);
    nxt(); commit("wrap7", 5'd7, 32'h7777_7777);
    nxt(); head = 3'd0; do_alloc(3'd0, 5'd1); pulse("wrap_gap", 1'b0);
    nxt(); do_wb(3'd0, 32'h1234_5678);
    nxt(); pulse("wrap0_wait", 1'b0);
    nxt(); commit("wrap0", 5'd1, 32'h1234_5678);
    nxt(); head = 3'd1; pulse("wrap_after", 1'b0);

    // alloc beats writeback to the same tag
    do_alloc(3'd1, 5'd5);
    nxt(); do_alloc(3'd1, 5'd6); do_wb(3'd1, 32'h0000_0BAD);
    for (int i = 0; i < 3; i++) begin
      nxt(); pulse("same_hold", 1'b0);
    end
    do_wb(3'd1, 32'h0000_600D);
    nxt(); pulse("same_wait", 1'b0);
    nxt(); commit("same", 5'd6, 32'h0000_600D);
    nxt(); head = 3'd2; pulse("same_after", 1'b0);

    // flush during ADVANCE with three valid entries left
    do_alloc(3'd2, 5'd20);
    nxt(); do_alloc(3'd3, 5'd21);
    nxt(); do_alloc(3'd4, 5'd22);
    nxt(); do_alloc(3'd5, 5'd23); do_wb(3'd2, 32'h2);
    nxt(); do_wb(3'd3, 32'h3); pulse("fl_wait", 1'b0);
    nxt(); flush = 1'b1; pulse("fl_adv", 1'b0);
    chk("fl_adv_notempty", rob_empty, 1'b0);
    chk("fl_adv_dest", commit_dest, 5'd20);
    nxt(); pulse("fl_next", 1'b0);
    chk("fl_empty", rob_empty, 1'b1);
    head = 3'd3; do_wb(3'd3, 32'h99);
    nxt(); do_wb(3'd4, 32'h98); pulse("fl_stale1", 1'b0);
    for (int i = 0; i < 3; i++) begin
      nxt(); pulse("fl_stale", 1'b0);
      chk("fl_stale_empty", rob_empty, 1'b1);
    end

    // asynchronous reset mid-ADVANCE
    do_alloc(3'd3, 5'd9);
    nxt(); do_wb(3'd3, 32'h5555_AAAA);
    nxt(); pulse("rsta_wait", 1'b0);
    nxt(); commit("rsta", 5'd9, 32'h5555_AAAA);
    #1 reset = 1'b1;
    pulse("rsta_drop", 1'b0);
    chk("rsta_dest", commit_dest, 5'd0);
    chk("rsta_data", commit_data, 32'd0);
    chk("rsta_empty", rob_empty, 1'b1);
    nxt(); reset = 1'b0;
    nxt(); pulse("rsta_after", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
